uart_frame_ctrl: RTL
====================

# uart_frame_ctrl

Byte-level command controller that sits behind the UART receiver and in front of the UART transmitter. It turns the received byte stream into framed register-bus transactions and returns a one-byte response per frame. It gives a host PC single-byte read/write access to the on-chip register file over the serial link.

## Interface
Parameters:
- ClkFreq, 10_000_000 — system clock in Hz; used only for the timeout count.
- BaudRate, 115200 — link baud rate; used only for the timeout count.
- TimeoutBytes, 2 — inter-byte timeout in byte times.
  - Timeout cycles = TimeoutBytes*10*(ClkFreq/BaudRate).
- RdWaitMax, 255 — maximum cycles to wait for i_bus_rvalid after a read strobe.

Ports:
- i_clk  in  1  — system clock, rising edge.
- i_rst  in  1  — reset; synchronous, active-high.
- i_rx_valid  in  1  — one-cycle strobe; i_rx_byte is valid.
- i_rx_byte  in  8  — received byte.
- o_tx_valid  out  1  — response byte valid.
- o_tx_byte  out  8  — response byte.
- i_tx_ready  in  1  — transmitter accepts o_tx_byte when high with o_tx_valid.
- o_bus_wr  out  1  — one-cycle write strobe.
- o_bus_rd  out  1  — one-cycle read strobe.
- o_bus_addr  out  8  — register address; held from strobe until return to IDLE.
- o_bus_wdata  out  8  — write data.
- i_bus_rdata  in  8  — read data; sampled when i_bus_rvalid is high.
- i_bus_rvalid  in  1  — read data valid strobe.
- o_busy  out  1  — high whenever state is not IDLE.
- o_err_cnt  out  8  — saturating frame error count.

## Operation
- Frame format: SYNC 0xA5, CMD, ADDR, DATA, CHK.
  - CHK = CMD ^ ADDR ^ DATA.
  - CMD 0x01 = write, 0x02 = read; for a read, DATA is ignored but still counted in CHK.
- States:
  - IDLE → S_CMD on i_rx_valid with byte 0xA5; any other byte is ignored.
  - S_CMD → S_ADDR → S_DATA → S_CHK, advancing one state per i_rx_valid and capturing each byte.
  - On the CHK byte: if the checksum fails or CMD is unknown → RESP with NAK 0x15 and o_err_cnt+1. Otherwise → EXEC.
  - EXEC:
    - Write: pulse o_bus_wr for one cycle → RESP with ACK 0x06.
    - Read: pulse o_bus_rd for one cycle → WAIT_RD.
  - WAIT_RD:
    - On i_bus_rvalid → RESP with i_bus_rdata.
    - After RdWaitMax cycles without i_bus_rvalid → RESP with NAK 0x15 and o_err_cnt+1.
  - RESP: assert o_tx_valid and hold o_tx_byte stable until i_tx_ready is high; the accepting cycle → IDLE.
- Bytes arriving in EXEC, WAIT_RD or RESP are dropped and not counted. A new frame needs a fresh SYNC.
- o_err_cnt saturates at 0xFF and never wraps.
- Reset mid-operation:
  - All outputs go to 0 and state returns to IDLE.
  - A pending tx byte is discarded.
  - o_err_cnt clears.

## Timing
- Reset values: o_tx_valid=0, o_tx_byte=0, o_bus_wr=0, o_bus_rd=0, o_bus_addr=0, o_bus_wdata=0, o_busy=0, o_err_cnt=0.
- CHK byte on cycle N:
  - Write: o_bus_wr at N+1; o_tx_valid at N+2.
  - NAK: o_tx_valid at N+1.
  - Read: o_bus_rd at N+1; o_tx_valid one cycle after i_bus_rvalid.
- i_bus_rvalid arriving in the same cycle as o_bus_rd (EXEC) is ignored; it is accepted from N+2 onward.
- If i_tx_ready is already high when o_tx_valid first rises, the byte transfers in that cycle.
- o_busy rises the cycle after SYNC is accepted and falls the cycle after the tx handshake.

## Configuration
- UART_FRAME_TIMEOUT_EN defined:
  - An inter-byte timer runs in S_CMD through S_CHK and clears on every i_rx_valid.
  - On expiry: → IDLE, o_err_cnt+1, no response byte.
- Not defined: no timer logic; a partial frame waits indefinitely for its next byte.

## Structure
- Package uart_frame_pkg holds:
  - State enum.
  - SYNC_BYTE 0xA5, CMD_WR 0x01, CMD_RD 0x02, ACK 0x06, NAK 0x15.
- One sub-module, uart_frame_timer: a loadable down-counter with clear and expiry strobe.
  - Used for the inter-byte timeout (macro-gated) and for the RdWaitMax read wait.

## Test plan
- Write frame A5 01 10 3C 2D → one o_bus_wr with addr 0x10, wdata 0x3C; tx byte 0x06; o_err_cnt stays 0.
- Read frame A5 02 10 00 12; i_bus_rvalid 3 cycles after o_bus_rd with rdata 0x3C → tx byte 0x3C.
- Bad checksum A5 01 10 3C 00 → no o_bus_wr; tx byte 0x15; o_err_cnt = 1.
- Noise bytes 00 FF 5A, then a valid write frame → only the valid frame executes; the noise bytes cause no error.
- With UART_FRAME_TIMEOUT_EN: A5 01, then silence beyond the timeout → return to IDLE; o_err_cnt+1; no tx byte.
- i_tx_ready held low 20 cycles during RESP → o_tx_valid and o_tx_byte stable throughout; one transfer when ready rises; assert i_rst mid-RESP → all outputs 0 next cycle.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared state encoding, byte codes and frame payload type for the UART frame controller.
package uart_frame_pkg;

  localparam int unsigned ByteW = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_CHK,
    ST_EXEC,
    ST_WAIT_RD,
    ST_RESP
  } state_e;

  localparam logic [ByteW-1:0] SYNC_BYTE = 8'hA5;
  localparam logic [ByteW-1:0] CMD_WR    = 8'h01;
  localparam logic [ByteW-1:0] CMD_RD    = 8'h02;
  localparam logic [ByteW-1:0] ACK       = 8'h06;
  localparam logic [ByteW-1:0] NAK       = 8'h15;

  // Bytes captured between SYNC and CHK.
  typedef struct packed {
    logic [ByteW-1:0] cmd;
    logic [ByteW-1:0] addr;
    logic [ByteW-1:0] data;
  } frame_t;

  function automatic logic frame_ok(input frame_t f, input logic [ByteW-1:0] chk);
    logic known;
    known = (f.cmd == CMD_WR) || (f.cmd == CMD_RD);
    return known && ((f.cmd ^ f.addr ^ f.data) == chk);
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Loadable down-counter with synchronous clear; o_expire_c pulses in the cycle the count reaches 1.
module uart_frame_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_clear,
  output logic             o_expire_c
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_load) begin
      count_d = i_load_val;
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expire_c = (count_q == Width'(1));

endmodule

// File: rtl/uart_frame_ctrl.sv
// Framed UART command controller: SYNC/CMD/ADDR/DATA/CHK to register bus, one response byte per frame.
// Define UART_FRAME_TIMEOUT_EN to abandon partial frames after an inter-byte timeout.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int unsigned ClkFreq      = 10_000_000,
  parameter int unsigned BaudRate     = 115200,
  parameter int unsigned TimeoutBytes = 2,
  parameter int unsigned RdWaitMax    = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rx_valid,
  input  logic [ByteW-1:0] i_rx_byte,
  output logic             o_tx_valid,
  output logic [ByteW-1:0] o_tx_byte,
  input  logic             i_tx_ready,
  output logic             o_bus_wr,
  output logic             o_bus_rd,
  output logic [ByteW-1:0] o_bus_addr,
  output logic [ByteW-1:0] o_bus_wdata,
  input  logic [ByteW-1:0] i_bus_rdata,
  input  logic             i_bus_rvalid,
  output logic             o_busy,
  output logic [ByteW-1:0] o_err_cnt
);

  localparam int unsigned TimeoutCycles = TimeoutBytes * 10 * (ClkFreq / BaudRate);
  localparam int unsigned TimerMax      = (TimeoutCycles > RdWaitMax) ? TimeoutCycles : RdWaitMax;
  localparam int unsigned TimerW        = $clog2(TimerMax + 1);

  state_e           state_q,     state_d;
  frame_t           frame_q,     frame_d;
  logic             tx_valid_q,  tx_valid_d;
  logic [ByteW-1:0] tx_byte_q,   tx_byte_d;
  logic             bus_wr_q,    bus_wr_d;
  logic             bus_rd_q,    bus_rd_d;
  logic [ByteW-1:0] bus_addr_q,  bus_addr_d;
  logic [ByteW-1:0] bus_wdata_q, bus_wdata_d;
  logic             busy_q,      busy_d;
  logic [ByteW-1:0] err_cnt_q,   err_cnt_d;

  logic              err_inc;
  logic              tmr_load;
  logic [TimerW-1:0] tmr_load_val;
  logic              tmr_clear;
  logic              tmr_expire_c;

  // Shared between the inter-byte timeout and the read-data wait; their states never overlap.
  uart_frame_timer #(
    .Width(TimerW)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (tmr_load),
    .i_load_val (tmr_load_val),
    .i_clear    (tmr_clear),
    .o_expire_c (tmr_expire_c)
  );

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    tx_byte_d    = tx_byte_q;
    bus_wr_d     = 1'b0;
    bus_rd_d     = 1'b0;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    err_inc      = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_rx_valid && (i_rx_byte == SYNC_BYTE)) begin
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (i_rx_valid) begin
          frame_d.cmd = i_rx_byte;
          state_d     = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (i_rx_valid) begin
          frame_d.addr = i_rx_byte;
          state_d      = ST_DATA;
        end
      end
      ST_DATA: begin
        if (i_rx_valid) begin
          frame_d.data = i_rx_byte;
          state_d      = ST_CHK;
        end
      end
      ST_CHK: begin
        if (i_rx_valid) begin
          if (frame_ok(frame_q, i_rx_byte)) begin
            state_d    = ST_EXEC;
            bus_addr_d = frame_q.addr;
            if (frame_q.cmd == CMD_WR) begin
              bus_wr_d    = 1'b1;
              bus_wdata_d = frame_q.data;
            end else begin
              bus_rd_d = 1'b1;
            end
          end else begin
            state_d   = ST_RESP;
            tx_byte_d = NAK;
            err_inc   = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (frame_q.cmd == CMD_WR) begin
          state_d   = ST_RESP;
          tx_byte_d = ACK;
        end else begin
          state_d      = ST_WAIT_RD;
          tmr_load     = 1'b1;
          tmr_load_val = TimerW'(RdWaitMax);
        end
      end
      ST_WAIT_RD: begin
        if (i_bus_rvalid) begin
          state_d   = ST_RESP;
          tx_byte_d = i_bus_rdata;
        end else if (tmr_expire_c) begin
          state_d   = ST_RESP;
          tx_byte_d = NAK;
          err_inc   = 1'b1;
        end
      end
      ST_RESP: begin
        if (i_tx_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef UART_FRAME_TIMEOUT_EN
    // Every accepted frame byte restarts the inter-byte window; silence past it abandons the frame.
    if (state_q inside {ST_CMD, ST_ADDR, ST_DATA, ST_CHK} && !i_rx_valid && tmr_expire_c) begin
      state_d = ST_IDLE;
      err_inc = 1'b1;
    end
    if (i_rx_valid && (state_d inside {ST_CMD, ST_ADDR, ST_DATA, ST_CHK})) begin
      tmr_load     = 1'b1;
      tmr_load_val = TimerW'(TimeoutCycles);
    end
`endif

    tmr_clear  = (state_d == ST_IDLE);
    tx_valid_d = (state_d == ST_RESP);
    busy_d     = (state_d != ST_IDLE);
    err_cnt_d  = err_cnt_q;
    if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + ByteW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      frame_q     <= '0;
      tx_valid_q  <= 1'b0;
      tx_byte_q   <= '0;
      bus_wr_q    <= 1'b0;
      bus_rd_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      busy_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      tx_valid_q  <= tx_valid_d;
      tx_byte_q   <= tx_byte_d;
      bus_wr_q    <= bus_wr_d;
      bus_rd_q    <= bus_rd_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      busy_q      <= busy_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_tx_valid  = tx_valid_q;
  assign o_tx_byte   = tx_byte_q;
  assign o_bus_wr    = bus_wr_q;
  assign o_bus_rd    = bus_rd_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_wdata = bus_wdata_q;
  assign o_busy      = busy_q;
  assign o_err_cnt   = err_cnt_q;

endmodule
